// File: rtl/pipe_trace_buffer.sv
// Trace recorder for the pipelined 16-bit CPU: circular pre/post-trigger capture
// of PC, per-stage IRs and write-back data, frozen for oldest-first readback.
module pipe_trace_buffer #(
  parameter int DATA_W    = 16,
  parameter int STAGES    = 4,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           cap_en,
  input  logic [DATA_W-1:0]              pc,
  input  logic [STAGES*DATA_W-1:0]       ir_bus,
  input  logic [DATA_W-1:0]              wd,
  input  logic                           arm,
  input  logic [1:0]                     trig_mode,
  input  logic [DATA_W-1:0]              trig_val,
  input  logic                           force_trig,
  input  logic                           rd_req,
  input  logic [$clog2(DEPTH)-1:0]       rd_addr,
  output logic [(STAGES+2)*DATA_W-1:0]   rd_data,
  output logic                           rd_valid,
  output logic [1:0]                     state,
  output logic [$clog2(DEPTH):0]         count,
  output logic [$clog2(DEPTH)-1:0]       trig_pos
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int ENTRY_W = (STAGES + 2) * DATA_W;

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  TRIG_OFS  = CNT_W'(POST_TRIG + 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             st;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  post_left;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic               hit;
  logic               wr_en;
  logic               rd_ok;
  logic [CNT_W-1:0]   count_inc;
  logic [CNT_W-1:0]   trig_full;
  logic [ADDR_W-1:0]  rd_phys;

  assign state = st;

  always_comb begin
    hit       = force_trig
              || (trig_mode == 2'd1 && pc == trig_val)
              || (trig_mode == 2'd2 && wd == trig_val);
    wr_en     = !arm && cap_en && (st == S_ARMED || st == S_POST);
    rd_ok     = !arm && rd_req && (st == S_DONE) && ({1'b0, rd_addr} < count);
    count_inc = (count == CNT_FULL) ? count : count + CNT_ONE;
    // Trigger index is derived from the count that will hold after this write.
    trig_full = count_inc - TRIG_OFS;
    // With count == DEPTH the low bits are zero, so oldest == wr_ptr.
    rd_phys   = wr_ptr - count[ADDR_W-1:0] + rd_addr;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= {wd, ir_bus, pc};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st        <= S_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      post_left <= '0;
      trig_pos  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= mem[rd_phys];

      if (arm) begin
        st        <= S_ARMED;
        wr_ptr    <= '0;
        count     <= '0;
        post_left <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_ONE;
        count  <= count_inc;
        if (st == S_ARMED) begin
          if (hit) begin
            if (POST_TRIG == 0) begin
              st       <= S_DONE;
              trig_pos <= trig_full[ADDR_W-1:0];
            end else begin
              st        <= S_POST;
              post_left <= POST_INIT;
            end
          end
        end else begin
          post_left <= post_left - ADDR_ONE;
          if (post_left == ADDR_ONE) begin
            st       <= S_DONE;
            trig_pos <= trig_full[ADDR_W-1:0];
          end
        end
      end
    end
  end

endmodule
